// File: rtl/arb_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr_pkg
// Purpose  : Shared types and helpers for the round-robin register arbiter.
//            Holds the arbiter state encoding and the pointer-advance helper.
// Revision : 1.0 - initial release
// ============================================================================
package arb_rr_pkg;

    localparam int unsigned c_STATE_W = 2;

    // Explicitly encoded so the state register width is fixed.
    typedef enum logic [c_STATE_W-1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    // Advance a round-robin index, wrapping from nreq-1 back to 0.
    function automatic int unsigned next_ptr(input int unsigned idx,
                                             input int unsigned nreq);
        if (idx + 1 >= nreq) begin
            return 0;
        end
        return idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/registro_param.sv
`default_nettype none
// ============================================================================
// Module   : registro_param
// Purpose  : Parameterized N-bit enable register. No reset of its own; the
//            owner clears it by forcing en=1 with d=0.
// Ports    : clk - clock, rising edge
//            en  - load enable
//            d   - data in  [N-1:0]
//            q   - data out [N-1:0]
// Revision : 1.0 - initial release
// ============================================================================
module registro_param #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : Combinational round-robin winner selection. Scans req starting
//            at ptr, then ptr+1, ... modulo NREQ, and reports the first set
//            bit.
// Ports    : req     - request vector [NREQ-1:0]
//            ptr     - highest-priority index [IW-1:0]
//            winner  - index of the selected requester [IW-1:0]
//            any_req - at least one request is pending
// Revision : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    int              w_idx;
    logic [IW-1:0]   w_cand;
    logic            w_found;

    assign any_req = |req;

    always_comb begin
        w_idx   = 0;
        w_cand  = '0;
        w_found = 1'b0;
        winner  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx  = (int'(ptr) + k) % NREQ;
            w_cand = IW'(w_idx);
            // First hit in scan order wins; later hits are ignored.
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                winner  = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/arbitro_registro_rr.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_registro_rr
// Purpose  : Round-robin write arbiter for one shared N-bit register.
//            IDLE picks a winner, WRITE loads its data (one cycle), ACK
//            returns a one-cycle acknowledge. One write per three cycles.
// Ports    : clk   - clock, rising edge
//            rst   - synchronous active-high reset
//            req   - per-requester write request [NREQ-1:0]
//            din   - flattened data, requester i at din[i*N +: N]
//            gnt   - one-hot grant, WRITE cycle only
//            ack   - one-hot acknowledge, ACK cycle only
//            q     - shared register contents [N-1:0]
//            owner - last requester that completed a write [IW-1:0]
//            busy  - high in WRITE and ACK
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_registro_rr
    import arb_rr_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] din,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [N-1:0]      q,
    output logic [IW-1:0]     owner,
    output logic              busy
);

    state_t          r_state;
    state_t          w_next_state;
    logic [IW-1:0]   r_sel;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;

    logic [IW-1:0]   w_winner;
    logic            w_any_req;
    logic            w_reg_en;
    logic [N-1:0]    w_sel_data;
    logic [N-1:0]    w_din_arr [NREQ];

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req     (req),
        .ptr     (r_ptr),
        .winner  (w_winner),
        .any_req (w_any_req)
    );

    // ------------------------------------------------------------------
    // Data mux: unflatten din, select the latched requester
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_din_arr[gi] = din[gi*N +: N];
    end

    assign w_sel_data = w_din_arr[r_sel];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    w_next_state = w_any_req ? WRITE : IDLE;
            WRITE:   w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode (state and sel only, no path from req)
    // ------------------------------------------------------------------
    always_comb begin
        gnt      = '0;
        ack      = '0;
        busy     = 1'b0;
        w_reg_en = 1'b0;
        unique case (r_state)
            WRITE: begin
                gnt[r_sel] = 1'b1;
                busy       = 1'b1;
                w_reg_en   = 1'b1;
            end
            ACK: begin
                ack[r_sel] = 1'b1;
                busy       = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // sel / ptr / owner bookkeeping. Reset wins over a WRITE in flight,
    // so ptr is not advanced by an aborted write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel   <= '0;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_sel <= w_winner;
            end
            if (r_state == WRITE) begin
                r_owner <= r_sel;
                r_ptr   <= IW'(next_ptr(32'(r_sel), NREQ));
            end
        end
    end

    assign owner = r_owner;

    // ------------------------------------------------------------------
    // Shared register. It has no reset pin, so reset is folded into the
    // load path: force a load of zero while rst is high.
    // ------------------------------------------------------------------
    registro_param #(
        .N (N)
    ) u_reg (
        .clk (clk),
        .en  (w_reg_en | rst),
        .d   (rst ? '0 : w_sel_data),
        .q   (q)
    );

endmodule
`default_nettype wire

// File: tb/tb_arbitro_registro_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_registro_rr
// Purpose  : Self-checking bench for arbitro_registro_rr (N=8, NREQ=4).
//            Expected writes are queued when a request is driven and checked
//            against ack/q/owner when the acknowledge appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_registro_rr;

    localparam int c_N    = 8;
    localparam int c_NREQ = 4;
    localparam int c_IW   = 2;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [c_NREQ-1:0]     req;
    logic [c_NREQ*c_N-1:0] din;
    logic [c_NREQ-1:0]     gnt;
    logic [c_NREQ-1:0]     ack;
    logic [c_N-1:0]        q;
    logic [c_IW-1:0]       owner;
    logic                  busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

    arbitro_registro_rr #(
        .N    (c_N),
        .NREQ (c_NREQ)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .ack   (ack),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every ack pulse must match the oldest queued write.
    always @(negedge clk) begin
        if (ack !== '0) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected_ack", 32'(ack), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("sb_ack", 32'(ack), 32'(1 << e.idx));
                check_val("sb_q", 32'(q), 32'(e.data));
                check_val("sb_owner", 32'(owner), 32'(e.idx));
            end
        end
    end

    // Called in the WRITE cycle. Walks WRITE -> ACK -> IDLE, then drives
    // req_idle in the IDLE cycle and req_next after the following edge.
    task automatic do_grant(input int i, input logic [7:0] data,
                            input logic [3:0] req_idle, input logic [3:0] req_next);
        sb_q.push_back('{idx: i, data: data});
        check_val("gnt_write", 32'(gnt), 32'(1 << i));
        check_val("busy_write", 32'(busy), 32'h1);
        check_val("ack_write", 32'(ack), 32'h0);
        step();
        check_val("busy_ack", 32'(busy), 32'h1);
        check_val("gnt_ack", 32'(gnt), 32'h0);
        step();
        check_val("busy_idle", 32'(busy), 32'h0);
        check_val("ack_idle", 32'(ack), 32'h0);
        req = req_idle;
        step();
        req = req_next;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b1111;
        for (int i = 0; i < c_NREQ; i++) begin
            din[i*c_N +: c_N] = 8'h10 + 8'(i);
        end

        // Reset held two cycles with all requests pending
        step();
        step();
        check_val("rst_gnt", 32'(gnt), 32'h0);
        check_val("rst_ack", 32'(ack), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_q", 32'(q), 32'h0);
        check_val("rst_owner", 32'(owner), 32'h0);
        rst = 1'b0;
        step();

        // Fairness: order 0,1,2,3,0 with drop-and-reraise after each ack
        do_grant(0, 8'h10, 4'b1110, 4'b1111);
        do_grant(1, 8'h11, 4'b1101, 4'b1111);
        do_grant(2, 8'h12, 4'b1011, 4'b1111);
        do_grant(3, 8'h13, 4'b0111, 4'b1111);
        do_grant(0, 8'h10, 4'b0000, 4'b0000);
        check_val("fair_idle_busy", 32'(busy), 32'h0);

        // Single requester, fixed latency
        req = 4'b0100;
        din[2*c_N +: c_N] = 8'hA5;
        step();
        do_grant(2, 8'hA5, 4'b0000, 4'b0000);
        check_val("single_q_hold", 32'(q), 32'hA5);

        // Wrap-around: ptr=3, req 1001 -> 3, then 0001 -> 0
        req = 4'b1001;
        step();
        do_grant(3, 8'h13, 4'b0001, 4'b0001);
        do_grant(0, 8'h10, 4'b0000, 4'b0000);

        // Request dropped during WRITE still completes
        req = 4'b0010;
        din[1*c_N +: c_N] = 8'h3C;
        step();
        req = 4'b0000;
        do_grant(1, 8'h3C, 4'b0000, 4'b0000);
        step();
        check_val("drop_idle_busy", 32'(busy), 32'h0);
        check_val("drop_idle_gnt", 32'(gnt), 32'h0);

        // Reset during WRITE for requester 2
        req = 4'b0100;
        din[2*c_N +: c_N] = 8'h5A;
        step();
        check_val("midrst_gnt", 32'(gnt), 32'h4);
        rst = 1'b1;
        step();
        check_val("midrst_ack", 32'(ack), 32'h0);
        check_val("midrst_busy", 32'(busy), 32'h0);
        check_val("midrst_gnt0", 32'(gnt), 32'h0);
        check_val("midrst_q", 32'(q), 32'h0);
        check_val("midrst_owner", 32'(owner), 32'h0);
        rst = 1'b0;
        req = 4'b0110;
        step();
        do_grant(1, 8'h3C, 4'b0000, 4'b0000);

        step();
        step();
        check_val("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbitro_registro_rr.md
Name: arbitro_registro_rr

Overview:
- Round-robin write arbiter and sequencer for one shared N-bit register.
- The shared register is built from the team's parameterized enable register (`registro_param`).
- NREQ requesters compete for write access. The arbiter grants one requester, loads that requester's data into the register, then returns a one-cycle acknowledge.
- Sits between the FSM datapath's producers and the shared state/data register.

Parameters:
- N, 8, data width of the shared register.
- NREQ, 4, number of requesters (≥2).
- IW, $clog2(NREQ), width of the requester index (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester write request, level, held until ack.
- din  input  NREQ*N  flattened write data; requester i occupies din[i*N +: N].
- gnt  output  NREQ  one-hot grant; high during the WRITE cycle only.
- ack  output  NREQ  one-hot acknowledge; high during the ACK cycle only.
- q  output  N  current contents of the shared register.
- owner  output  IW  index of the last requester that completed a write.
- busy  output  1  high in WRITE and ACK.

Behaviour:
- Reset: synchronous, active-high. Evaluated at the clk edge where rst=1. Reset values:
  - state=IDLE, ptr=0
  - gnt=0, ack=0, busy=0
  - owner=0, q=0
- Reset overrides everything, including an operation in progress.
- Register reset: the shared register instance has no reset of its own. The arbiter drives en = reg_en | rst and d = rst ? '0 : selected data.
- States (enum): IDLE, WRITE, ACK.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise choose winner w as the first set bit of req, scanning ptr, ptr+1, … mod NREQ.
  - Latch w into an internal sel register and go to WRITE.
- WRITE (exactly one cycle):
  - gnt[sel]=1, busy=1, reg_en=1, d=din[sel].
  - At the closing edge: q <= din[sel], owner <= sel, ptr <= (sel+1) mod NREQ, go to ACK.
- ACK (exactly one cycle):
  - ack[sel]=1, busy=1.
  - Go to IDLE.
- Latency: req rises, sampled in IDLE at edge k. Then:
  - gnt is high in cycle k+1.
  - q is updated at edge k+2.
  - ack is high in cycle k+2.
  - The next grant occurs no earlier than cycle k+4.
  - Throughput is one write per 3 cycles.
- Requester protocol:
  - Hold req and din stable from raising req through the WRITE cycle.
  - Deassert req in the cycle after ack.
  - A req still high in IDLE after ack is treated as a new request. Since ptr has moved past that requester, it has the lowest priority.
- Req dropped during WRITE or ACK: the write still completes and ack is still pulsed. The arbiter does not abort.
- Simultaneous requests: exactly one grant. Ties are resolved by ptr order. Starvation-free: every requester waits at most NREQ-1 other writes.
- ptr and sel wrap from NREQ-1 to 0.
- Outputs gnt, ack and busy are decoded from state and sel only (Moore). No combinational path from req to any output.
- rst asserted in WRITE takes priority: q <= 0, no ack is issued, and ptr is not advanced.

Decomposition:
- Package arb_rr_pkg: state_t enum {IDLE, WRITE, ACK}; function next_ptr(idx, nreq).
- Sub-module rr_picker:
  - Combinational.
  - Inputs: req, ptr. Outputs: winner index, any_req.
- The shared register is the existing registro_param, instantiated with parameter N.
- Top level holds: FSM, sel/ptr/owner registers, data mux, output decode.

Test Plan (N=8, NREQ=4):
- Reset values: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, ack=0, busy=0, q=8'h00, owner=0. After release, the first grant goes to requester 0.
- Single requester: req=4'b0100, din[2]=8'hA5 at edge k -> gnt=4'b0100 in cycle k+1; q=8'hA5, ack=4'b0100 and owner=2 in cycle k+2; busy low from cycle k+3.
- Fairness: req=4'b1111 held continuously, each requester dropping req after its ack and re-raising it the next cycle, din[i]=8'h10+i -> grant order 0,1,2,3,0. q values in that order: 8'h10, 8'h11, 8'h12, 8'h13, 8'h10.
- Wrap-around and tie-break: ptr=3 (after a grant to requester 2), req=4'b1001 -> requester 3 wins. Next, req=4'b0001 -> requester 0 wins; ptr becomes 1.
- Drop during WRITE: req[1] goes 1 -> 0 in the WRITE cycle with din[1]=8'h3C -> q=8'h3C and ack=4'b0010 is still pulsed; FSM returns to IDLE.
- Reset mid-operation: rst=1 in the WRITE cycle for requester 2 -> next cycle state=IDLE, q=8'h00, ack=0, ptr=0. Then req=4'b0110 -> requester 1 is granted.
